// File: rtl/vga_fml_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_fml_pkg : FML burst geometry and the burst state encoding shared by
//               the VGA FML slave and the LCD FML master.  Rev 1.0
// ---------------------------------------------------------------------------
package vga_fml_pkg;

  localparam int FML_BURST_LEN = 8;
  localparam int FML_BEAT_BITS = 3;
  localparam int FML_IDX_LSB   = 1;
  localparam int FML_IDX_MSB   = 3;
  localparam int FML_TAG_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RFETCH = 2'd1,
    ST_RBURST = 2'd2,
    ST_WBURST = 2'd3
  } fml_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_vram_sram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_vram_sram : single-port synchronous video RAM, 16-bit words, per-byte
//                 write enables, registered read data.  Rev 1.0
// ---------------------------------------------------------------------------
module vga_vram_sram #(
  parameter int ram_adr_bits = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ram_adr_bits-1:0] adr,
  input  logic [1:0]              we,
  input  logic [15:0]             di,
  output logic [15:0]             dq
);

  // One byte-wide array per lane keeps each array written from a single process.
  for (genvar b = 0; b < 2; b++) begin : g_lane
    logic [7:0] mem [2**ram_adr_bits];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[b]) mem[adr] <= di[8*b +: 8];
      if (!rst_n) q <= '0;
      else        q <= mem[adr];
    end
  end

  assign dq = {g_lane[1].q, g_lane[0].q};

endmodule
`default_nettype wire

// File: rtl/vga_vram_fml_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_vram_fml_slave : FML burst responder for the VGA video RAM with a
//                      one-line DCB cache of the last read burst.  Rev 1.0
// ---------------------------------------------------------------------------
module vga_vram_fml_slave
  import vga_fml_pkg::*;
#(
  parameter int fml_depth    = 20,
  parameter int ram_adr_bits = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [fml_depth-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  output logic                 fml_ack,
  input  logic [1:0]           fml_sel,
  input  logic [15:0]          fml_di,
  output logic [15:0]          fml_do,
  input  logic                 dcb_stb,
  input  logic [fml_depth-1:0] dcb_adr,
  output logic [15:0]          dcb_dat,
  output logic                 dcb_hit
);

  localparam int TAG_W = fml_depth - FML_TAG_LSB;

  typedef logic [FML_BEAT_BITS-1:0] beat_t;
  typedef logic [TAG_W-1:0]         tag_t;

  fml_state_t state;
  beat_t      beat;
  tag_t       burst_tag;
  tag_t       line_tag;
  logic       line_valid;
  logic       fill_en;
  logic       lock_q;
  logic       rd_ack;
  logic [15:0] line [FML_BURST_LEN];

  tag_t        req_tag;
  tag_t        probe_tag;
  beat_t       probe_idx;
  logic        locked;
  logic        wr_block;
  logic        rd_start;
  logic        wr_start;
  logic        last;
  logic        fill_wr;
  tag_t        ram_tag;
  beat_t       ram_idx;
  logic [1:0]  ram_we;
  logic [15:0] ram_q;
  logic [ram_adr_bits-1:0]        ram_adr;
  logic [TAG_W+FML_BEAT_BITS-1:0] ram_word;
  logic        unused_bits;

  assign req_tag   = fml_adr[fml_depth-1:FML_TAG_LSB];
  assign probe_tag = dcb_adr[fml_depth-1:FML_TAG_LSB];
  assign probe_idx = dcb_adr[FML_IDX_MSB:FML_IDX_LSB];

  // The lock outlives dcb_stb by one cycle so a falling probe releases on the next edge.
  assign locked   = dcb_stb | lock_q;
  assign wr_block = locked & (req_tag == line_tag);
  assign rd_start = rst_n & (state == ST_IDLE) & fml_stb & ~fml_we;
  assign wr_start = rst_n & (state == ST_IDLE) & fml_stb & fml_we & ~wr_block;
  assign last     = (beat == beat_t'(FML_BURST_LEN - 1));
  assign fill_wr  = rst_n & ((state == ST_RFETCH) | (state == ST_RBURST)) & fill_en & ~locked;

  assign fml_ack = rd_ack | wr_start;
  assign fml_do  = ram_q;

  always_comb begin
    ram_tag = burst_tag;
    ram_idx = beat;
    ram_we  = 2'b00;
    case (state)
      ST_IDLE: begin
        ram_tag = req_tag;
        ram_idx = '0;
        if (wr_start) ram_we = fml_sel;
      end
      ST_RFETCH, ST_RBURST: ram_idx = beat + beat_t'(1);
      ST_WBURST: if (rst_n) ram_we = fml_sel;
      default: ;
    endcase
  end

  // High tag bits beyond the RAM size are dropped so addresses wrap.
  assign ram_word    = {ram_tag, ram_idx};
  assign ram_adr     = ram_word[ram_adr_bits-1:0];
  assign unused_bits = ^{fml_adr[FML_TAG_LSB-1:0], dcb_adr[FML_IDX_LSB-1:0],
                         ram_word[TAG_W+FML_BEAT_BITS-1:ram_adr_bits]};

  vga_vram_sram #(
    .ram_adr_bits(ram_adr_bits)
  ) u_sram (
    .clk  (clk),
    .rst_n(rst_n),
    .adr  (ram_adr),
    .we   (ram_we),
    .di   (fml_di),
    .dq   (ram_q)
  );

  always_ff @(posedge clk) begin
    if (fill_wr) line[beat] <= ram_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat       <= '0;
      rd_ack     <= 1'b0;
      line_valid <= 1'b0;
      fill_en    <= 1'b0;
      lock_q     <= 1'b0;
      burst_tag  <= '0;
      line_tag   <= '0;
      dcb_hit    <= 1'b0;
      dcb_dat    <= '0;
    end else begin
      lock_q  <= dcb_stb;
      rd_ack  <= rd_start;
      dcb_hit <= dcb_stb & line_valid & (probe_tag == line_tag);
      dcb_dat <= dcb_stb ? line[probe_idx] : 16'h0000;

      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            burst_tag <= req_tag;
            beat      <= '0;
            fill_en   <= ~locked;
            if (!locked) line_valid <= 1'b0;
            state     <= ST_RFETCH;
          end else if (wr_start) begin
            burst_tag <= req_tag;
            beat      <= beat_t'(1);
            if (req_tag == line_tag) line_valid <= 1'b0;
            state     <= ST_WBURST;
          end
        end
        ST_RFETCH, ST_RBURST: begin
          beat <= beat + beat_t'(1);
          // A lock seen anywhere in the burst abandons the refill for this line.
          if (locked) fill_en <= 1'b0;
          if (last) begin
            if (fill_en && !locked) begin
              line_valid <= 1'b1;
              line_tag   <= burst_tag;
            end
            state <= ST_IDLE;
          end else begin
            state <= ST_RBURST;
          end
        end
        ST_WBURST: begin
          beat <= beat + beat_t'(1);
          if (last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_vram_fml_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_vram_fml_slave : directed bench for the VGA video RAM FML slave.
//                         Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_vram_fml_slave;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [19:0] fml_adr = '0;
  logic        fml_stb = 1'b0;
  logic        fml_we  = 1'b0;
  logic [1:0]  fml_sel = '0;
  logic [15:0] fml_di  = '0;
  logic        dcb_stb = 1'b0;
  logic [19:0] dcb_adr = '0;
  logic        fml_ack;
  logic [15:0] fml_do;
  logic [15:0] dcb_dat;
  logic        dcb_hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_vram_fml_slave #(
    .fml_depth   (20),
    .ram_adr_bits(14)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fml_adr(fml_adr),
    .fml_stb(fml_stb),
    .fml_we (fml_we),
    .fml_ack(fml_ack),
    .fml_sel(fml_sel),
    .fml_di (fml_di),
    .fml_do (fml_do),
    .dcb_stb(dcb_stb),
    .dcb_adr(dcb_adr),
    .dcb_dat(dcb_dat),
    .dcb_hit(dcb_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge, outputs sampled 1 unit later.
  task automatic wr_burst(input logic [19:0] a, input logic [1:0] s,
                          input logic [15:0] d0, input bit inc);
    int n;
    fml_adr = a; fml_we = 1'b1; fml_sel = s; fml_di = d0; fml_stb = 1'b1;
    #1;
    n = 0;
    while (fml_ack !== 1'b1 && n < 16) begin
      tick(); n++; #1;
    end
    chk("wr_ack", {15'd0, fml_ack}, 16'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      fml_stb = 1'b0;
      fml_di  = inc ? d0 + 16'(k) : d0;
      #1;
      if (k == 1) chk("wr_ack_once", {15'd0, fml_ack}, 16'd0);
    end
    tick();
    fml_we = 1'b0; fml_sel = 2'b00;
  endtask

  task automatic rd_burst(input logic [19:0] a, input logic [15:0] base,
                          input logic [15:0] step, input string tag);
    fml_adr = a; fml_we = 1'b0; fml_stb = 1'b1;
    #1 chk({tag, "_ack_T"}, {15'd0, fml_ack}, 16'd0);
    tick(); #1;
    chk({tag, "_ack_T1"}, {15'd0, fml_ack}, 16'd1);
    chk({tag, "_w0"}, fml_do, base);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (k == 1) fml_stb = 1'b0;
      #1;
      if (k == 1) chk({tag, "_ack_T2"}, {15'd0, fml_ack}, 16'd0);
      chk({tag, "_w"}, fml_do, base + step * 16'(k));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(); tick(); #1;
    chk("rst_ack", {15'd0, fml_ack}, 16'd0);
    chk("rst_do", fml_do, 16'h0000);
    chk("rst_hit", {15'd0, dcb_hit}, 16'd0);
    chk("rst_dat", dcb_dat, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Preload line 0x00200 with A000..A007 and line 0 with 5000..5007
    wr_burst(20'h00200, 2'b11, 16'hA000, 1'b1);
    wr_burst(20'h00000, 2'b11, 16'h5000, 1'b1);

    rd_burst(20'h00200, 16'hA000, 16'h0001, "rd1");

    // Probe sweep over the freshly cached line
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        dcb_stb = 1'b1;
        dcb_adr = 20'h00200 + 20'(2 * k);
      end else begin
        dcb_stb = 1'b0;
      end
      #1;
      if (k > 0) begin
        chk("dcb_hit", {15'd0, dcb_hit}, 16'd1);
        chk("dcb_dat", dcb_dat, 16'hA000 + 16'(k - 1));
      end
    end
    tick(); #1 chk("dcb_idle_hit", {15'd0, dcb_hit}, 16'd0);
    tick();

    // Low-byte write invalidates the cached line
    wr_burst(20'h00200, 2'b01, 16'hFFFF, 1'b0);
    dcb_stb = 1'b1; dcb_adr = 20'h00200;
    tick();
    dcb_stb = 1'b0;
    #1 chk("inval_hit", {15'd0, dcb_hit}, 16'd0);
    tick(); tick();
    rd_burst(20'h00200, 16'hA0FF, 16'h0000, "reread");

    // Locked cache: write to the cached tag waits for the lock to end
    dcb_stb = 1'b1; dcb_adr = 20'h0020E;
    tick(); #1;
    chk("refill_hit", {15'd0, dcb_hit}, 16'd1);
    chk("refill_dat", dcb_dat, 16'hA0FF);
    fml_adr = 20'h00200; fml_we = 1'b1; fml_sel = 2'b11; fml_di = 16'h1234; fml_stb = 1'b1;
    #1 chk("lock_hold0", {15'd0, fml_ack}, 16'd0);
    tick(); #1 chk("lock_hold1", {15'd0, fml_ack}, 16'd0);
    tick(); #1 chk("lock_hold2", {15'd0, fml_ack}, 16'd0);
    tick();
    dcb_stb = 1'b0;
    #1 chk("lock_tail", {15'd0, fml_ack}, 16'd0);
    tick(); #1 chk("lock_release", {15'd0, fml_ack}, 16'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      fml_stb = 1'b0;
      if (k == 1) begin
        #1 chk("lock_ack_once", {15'd0, fml_ack}, 16'd0);
      end
    end
    tick();
    fml_we = 1'b0; fml_sel = 2'b00;
    rd_burst(20'h00200, 16'h1234, 16'h0000, "after_lock");

    // Address beyond the RAM size wraps to word 0
    rd_burst(20'h40000, 16'h5000, 16'h0001, "wrap");

    // Reset during beat 4 of a read
    fml_adr = 20'h00200; fml_we = 1'b0; fml_stb = 1'b1;
    tick();
    tick(); fml_stb = 1'b0;
    tick(); tick(); tick();
    #1 chk("pre_rst_do", fml_do, 16'h1234);
    rst_n = 1'b0;
    tick(); #1;
    chk("midrst_ack", {15'd0, fml_ack}, 16'd0);
    chk("midrst_do", fml_do, 16'h0000);
    chk("midrst_hit", {15'd0, dcb_hit}, 16'd0);
    chk("midrst_dat", dcb_dat, 16'h0000);
    rst_n = 1'b1;
    tick();
    dcb_stb = 1'b1; dcb_adr = 20'h00200;
    tick();
    dcb_stb = 1'b0;
    #1 chk("post_rst_hit", {15'd0, dcb_hit}, 16'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
